// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key schedule: one 32-bit schedule word per clock into a round-key
// table, with a registered round-key read port. Optional macro AES_KEYSCHED_EQINV_EN adds equivalent-inverse keys.
module aes_key_schedule_seq #(
  parameter int NK_MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic [3:0]   rk_idx,
  input  logic         rk_rev,
  input  logic         rk_eqinv,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  output logic [0:0]   fsm_state
);
  localparam int TW = 4 * (NK_MAX + 7);
  localparam int IW = $clog2(TW);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] EXPAND = 1'b1;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] ri;
    ri = 8'hff - b;
    return SBOX[{ri, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Handshake: start is a level sampled on each rising edge; it is accepted only when
  // fsm_state==IDLE, busy is high for the whole expansion, done and err are single-cycle pulses.
  logic [0:0]    state;
  logic [31:0]   w [TW];
  logic [IW-1:0] i;
  logic [2:0]    j;
  logic [3:0]    nk;
  logic [3:0]    nr_last;
  logic [7:0]    rcon;

  logic [3:0]    req_nk;
  logic          illegal;
  logic [IW-1:0] last_idx;
  logic [31:0]   prev_word, far_word, sub_in, sub_out, temp, new_word;

  always_comb begin
    req_nk = 4'd0;
    case (key_len)
      2'd0:    req_nk = 4'd4;
      2'd1:    req_nk = 4'd6;
      2'd2:    req_nk = 4'd8;
      default: req_nk = 4'd0;
    endcase
  end

  assign illegal  = (key_len == 2'd3) || (int'(req_nk) > NK_MAX);
  assign last_idx = IW'(4 * int'(nk) + 27);

  // The single S-box row sits behind the RotWord/plain mux so both key-schedule cases share it.
  always_comb begin
    prev_word = w[i - IW'(1)];
    far_word  = w[i - IW'(nk)];
    sub_in    = (j == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    sub_out   = sub_word(sub_in);
    temp      = prev_word;
    if (j == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && j == 3'd4)
      temp = sub_out;
    new_word  = far_word ^ temp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      nk       <= 4'd4;
      nr_last  <= 4'd10;
      rcon     <= 8'h01;
      done     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (illegal) begin
              err <= 1'b1;
            end else begin
              state    <= EXPAND;
              nk       <= req_nk;
              i        <= IW'(req_nk);
              j        <= '0;
              rcon     <= 8'h01;
              rk_valid <= 1'b0;
            end
          end
        end
        EXPAND: begin
          i <= i + IW'(1);
          j <= (j == 3'(nk - 4'd1)) ? 3'd0 : j + 3'd1;
          if (j == 3'd0)
            rcon <= xt(rcon);
          if (i == last_idx) begin
            state    <= IDLE;
            done     <= 1'b1;
            rk_valid <= 1'b1;
            nr_last  <= nk + 4'd6;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The table itself is not reset: rk_valid alone says whether its contents mean anything.
  always_ff @(posedge clk) begin
    if (rst_n && state == IDLE && start && !illegal) begin
      for (int k = 0; k < NK_MAX; k++)
        if (k < int'(req_nk))
          w[k] <= key_in[255 - 32 * k -: 32];
    end else if (rst_n && state == EXPAND) begin
      w[i] <= new_word;
    end
  end

  logic [3:0]    eff_r;
  logic          in_range;
  logic [IW-1:0] base;
  logic [127:0]  rk_sel;

`ifdef AES_KEYSCHED_EQINV_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[31 - 8 * k -: 8];
      x2[k] = xt(a[k]);
      x4[k] = xt(x2[k]);
      x8[k] = xt(x4[k]);
      m9[k] = x8[k] ^ a[k];
      mb[k] = x8[k] ^ x2[k] ^ a[k];
      md[k] = x8[k] ^ x4[k] ^ a[k];
      me[k] = x8[k] ^ x4[k] ^ x2[k];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`else
  logic unused_eqinv;
  assign unused_eqinv = rk_eqinv;
`endif

  always_comb begin
    eff_r    = rk_rev ? (nr_last - rk_idx) : rk_idx;
    in_range = (rk_idx <= nr_last);
    base     = IW'({eff_r, 2'b00});
    rk_sel   = {w[base], w[base + IW'(1)], w[base + IW'(2)], w[base + IW'(3)]};
`ifdef AES_KEYSCHED_EQINV_EN
    if (rk_eqinv && eff_r != 4'd0 && eff_r != nr_last)
      rk_sel = {inv_mix_col(rk_sel[127:96]), inv_mix_col(rk_sel[95:64]),
                inv_mix_col(rk_sel[63:32]), inv_mix_col(rk_sel[31:0])};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rk_out <= '0;
    else
      rk_out <= in_range ? rk_sel : 128'h0;
  end

  assign busy      = (state == EXPAND);
  assign fsm_state = state;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq: FIPS-197 vectors plus random keys against a
// reference key expansion built from GF(2^8) arithmetic.
module tb_aes_key_schedule_seq;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key_in = '0;
  logic         busy, done, err, rk_valid;
  logic [3:0]   rk_idx = 4'd0;
  logic         rk_rev = 1'b0;
  logic         rk_eqinv = 1'b0;
  logic [127:0] rk_out;
  logic [0:0]   fsm_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]   sb [256];
  logic [31:0]  mw [60];
  logic [127:0] exp_q [$];
  logic [127:0] got_q [$];

`ifdef AES_KEYSCHED_EQINV_EN
  localparam bit EQINV_ON = 1'b1;
`else
  localparam bit EQINV_ON = 1'b0;
`endif

  aes_key_schedule_seq #(.NK_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .err(err), .rk_idx(rk_idx), .rk_rev(rk_rev),
    .rk_eqinv(rk_eqinv), .rk_out(rk_out), .rk_valid(rk_valid), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h0; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < n; k++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    int nw;
    nw = 4 * (nk + 7);
    for (int k = 0; k < nk; k++) mw[k] = key[255 - 32 * k -: 32];
    for (int k = nk; k < nw; k++) begin
      t = mw[k - 1];
      if (k % nk == 0)
        t = sub_w({t[23:0], t[31:24]}) ^ {rcon_of(k / nk), 24'h0};
      else if (nk > 6 && k % nk == 4)
        t = sub_w(t);
      mw[k] = mw[k - nk] ^ t;
    end
  endtask

  function automatic logic [127:0] inv_mix128(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0] a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127 - 32 * c -: 8];
      a1 = x[119 - 32 * c -: 8];
      a2 = x[111 - 32 * c -: 8];
      a3 = x[103 - 32 * c -: 8];
      y[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      y[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      y[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      y[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return y;
  endfunction

  task automatic expect_rounds(input int nk, input logic rev, input logic eq);
    int nr, er;
    logic [127:0] e;
    nr = nk + 6;
    for (int r = 0; r <= nr; r++) begin
      er = rev ? nr - r : r;
      e = {mw[4 * er], mw[4 * er + 1], mw[4 * er + 2], mw[4 * er + 3]};
      if (EQINV_ON && eq && er > 0 && er < nr) e = inv_mix128(e);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input logic [1:0] len, input logic [255:0] key);
    key_len = len; key_in = key; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic read_round(input logic [3:0] idx, input logic rev, input logic eq,
                            output logic [127:0] got);
    rk_idx = idx; rk_rev = rev; rk_eqinv = eq;
    @(posedge clk); #1;
    got = rk_out;
  endtask

  task automatic read_rounds(input int nk, input logic rev, input logic eq);
    logic [127:0] g;
    for (int r = 0; r <= nk + 6; r++) begin
      read_round(4'(r), rev, eq, g);
      got_q.push_back(g);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, err, rk_valid} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got busy/done/err/valid=%b expected 0000", {busy, done, err, rk_valid});
    end
    tests_run++;
    if (rk_out !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_rk_out: got %h expected 0", rk_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_aes128();
    logic [255:0] key;
    logic [127:0] g, e;
    int n;
    key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    model_expand(key, 4);
    do_start(2'd0, key);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL aes128_busy: got %b expected 1", busy); end
    wait_done(n);
    tests_run++;
    if (done !== 1'b1 || n != 41) begin
      tests_failed++; $display("FAIL aes128_latency: got done=%b cycle %0d expected cycle 41", done, n);
    end
    tests_run++;
    if (busy !== 1'b0 || rk_valid !== 1'b1) begin
      tests_failed++; $display("FAIL aes128_flags_at_done: got busy=%b valid=%b expected 0 1", busy, rk_valid);
    end
    read_round(4'd10, 1'b0, 1'b0, g);
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL aes128_done_pulse: got %b expected 0", done); end
    tests_run++;
    if (g !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      tests_failed++; $display("FAIL aes128_round10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", g);
    end
    read_round(4'd0, 1'b0, 1'b0, g);
    tests_run++;
    if (g !== key[255:128]) begin tests_failed++; $display("FAIL aes128_round0: got %h expected %h", g, key[255:128]); end
    // registered read: changing the index must not disturb rk_out before the next edge
    rk_idx = 4'd5; #2;
    tests_run++;
    if (rk_out !== key[255:128]) begin tests_failed++; $display("FAIL aes128_read_hold: got %h expected %h", rk_out, key[255:128]); end
    @(posedge clk); #1;
    expect_rounds(4, 1'b0, 1'b0);
    read_rounds(4, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL aes128_sweep: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_aes192();
    logic [255:0] key;
    logic [127:0] g, e;
    int n;
    key = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    model_expand(key, 6);
    do_start(2'd1, key);
    wait_done(n);
    tests_run++;
    if (done !== 1'b1 || n != 47) begin
      tests_failed++; $display("FAIL aes192_latency: got done=%b cycle %0d expected cycle 47", done, n);
    end
    read_round(4'd12, 1'b0, 1'b0, g);
    tests_run++;
    if (g[31:0] !== 32'h01002202) begin tests_failed++; $display("FAIL aes192_last_word: got %h expected 01002202", g[31:0]); end
    read_round(4'd12, 1'b1, 1'b0, g);
    tests_run++;
    if (g !== key[255:128]) begin tests_failed++; $display("FAIL aes192_rev12: got %h expected %h", g, key[255:128]); end
    expect_rounds(6, 1'b0, 1'b0);
    read_rounds(6, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL aes192_sweep: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_aes256();
    logic [255:0] key;
    logic [127:0] g, e;
    int n;
    key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    model_expand(key, 8);
    do_start(2'd2, key);
    wait_done(n);
    tests_run++;
    if (done !== 1'b1 || n != 53) begin
      tests_failed++; $display("FAIL aes256_latency: got done=%b cycle %0d expected cycle 53", done, n);
    end
    read_round(4'd14, 1'b0, 1'b0, g);
    tests_run++;
    if (g[31:0] !== 32'h706c631e) begin tests_failed++; $display("FAIL aes256_last_word: got %h expected 706c631e", g[31:0]); end
    expect_rounds(8, 1'b1, 1'b0);
    read_rounds(8, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL aes256_rev_sweep: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_out_of_range();
    logic [127:0] g;
    int n;
    model_expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    do_start(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
    wait_done(n);
    for (int idx = 11; idx < 16; idx++) begin
      read_round(4'(idx), idx[0], 1'b0, g);
      tests_run++;
      if (g !== 128'h0) begin tests_failed++; $display("FAIL oob_idx%0d: got %h expected 0", idx, g); end
    end
  endtask

  task automatic test_illegal_key_len();
    logic [127:0] g, e;
    do_start(2'd3, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    tests_run++;
    if ({err, busy, rk_valid} !== 3'b101) begin
      tests_failed++; $display("FAIL illegal_err: got err/busy/valid=%b expected 101", {err, busy, rk_valid});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({err, busy, rk_valid} !== 3'b001) begin
      tests_failed++; $display("FAIL illegal_err_pulse: got err/busy/valid=%b expected 001", {err, busy, rk_valid});
    end
    e = {mw[40], mw[41], mw[42], mw[43]};
    read_round(4'd10, 1'b0, 1'b0, g);
    tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL illegal_table_kept: got %h expected %h", g, e); end
  endtask

  task automatic test_start_during_expand();
    logic [255:0] key;
    logic [127:0] g, e;
    int n;
    key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    model_expand(key, 4);
    do_start(2'd0, key);
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      if (n == 10) begin
        start = 1'b1; key_len = 2'd2;
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      tests_run++;
      if (err !== 1'b0) begin tests_failed++; $display("FAIL busy_start_err at cycle %0d: got %b expected 0", n, err); end
    end
    start = 1'b0;
    tests_run++;
    if (done !== 1'b1 || n != 41) begin
      tests_failed++; $display("FAIL busy_start_latency: got done=%b cycle %0d expected cycle 41", done, n);
    end
    expect_rounds(4, 1'b0, 1'b0);
    read_rounds(4, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL busy_start_sweep: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] key_a, key_b;
    logic [127:0] g, e;
    int n;
    key_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 64'h0};
    key_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_start(2'd1, key_a);
    wait_done(n);
    tests_run++;
    if (done !== 1'b1 || n != 47) begin
      tests_failed++; $display("FAIL b2b_first_latency: got done=%b cycle %0d expected cycle 47", done, n);
    end
    do_start(2'd2, key_b);
    tests_run++;
    if (busy !== 1'b1 || rk_valid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_accept: got busy=%b valid=%b expected 1 0", busy, rk_valid);
    end
    wait_done(n);
    tests_run++;
    if (done !== 1'b1 || n != 53) begin
      tests_failed++; $display("FAIL b2b_second_latency: got done=%b cycle %0d expected cycle 53", done, n);
    end
    model_expand(key_b, 8);
    expect_rounds(8, 1'b0, 1'b0);
    read_rounds(8, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL b2b_sweep: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_reset_mid_expand();
    logic [255:0] key;
    logic [127:0] g;
    int n;
    key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    rk_idx = 4'd10; rk_rev = 1'b0; rk_eqinv = 1'b0;
    do_start(2'd0, key);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({busy, done, err, rk_valid} !== 4'b0000 || rk_out !== 128'h0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got flags=%b rk_out=%h expected 0000 and 0", {busy, done, err, rk_valid}, rk_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(2'd0, key);
    wait_done(n);
    tests_run++;
    if (done !== 1'b1 || n != 41) begin
      tests_failed++; $display("FAIL midreset_restart_latency: got done=%b cycle %0d expected cycle 41", done, n);
    end
    read_round(4'd10, 1'b0, 1'b0, g);
    tests_run++;
    if (g !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      tests_failed++; $display("FAIL midreset_round10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", g);
    end
  endtask

  task automatic test_random();
    logic [255:0] key;
    logic [127:0] g, e;
    logic rev;
    int n, nk;
    for (int t = 0; t < 6; t++) begin
      nk = 4 + 2 * (t % 3);
      rev = 1'($urandom_range(0, 1));
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      model_expand(key, nk);
      do_start(2'(t % 3), key);
      wait_done(n);
      tests_run++;
      if (done !== 1'b1 || n != 4 * (nk + 7) - nk + 1) begin
        tests_failed++; $display("FAIL rand%0d_latency: got done=%b cycle %0d expected cycle %0d", t, done, n, 4 * (nk + 7) - nk + 1);
      end
      expect_rounds(nk, rev, 1'b0);
      read_rounds(nk, rev, 1'b0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        tests_run++;
        if (g !== e) begin tests_failed++; $display("FAIL rand%0d_sweep: got %h expected %h", t, g, e); end
      end
    end
  endtask

  task automatic test_eqinv();
    logic [127:0] g, e;
    int n;
    model_expand(256'h0, 4);
    do_start(2'd0, 256'h0);
    wait_done(n);
    read_round(4'd1, 1'b0, 1'b1, g);
    e = EQINV_ON ? inv_mix128({4{32'h62636363}}) : {4{32'h62636363}};
    tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL eqinv_round1: got %h expected %h", g, e); end
    expect_rounds(4, 1'b0, 1'b1);
    read_rounds(4, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL eqinv_sweep: got %h expected %h", g, e); end
    end
    rk_eqinv = 1'b0;
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_out_of_range();
    test_illegal_key_len();
    test_start_during_expand();
    test_back_to_back();
    test_reset_mid_expand();
    test_random();
    test_eqinv();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
